dma_rd_arbiter: RTL and testbench

Round-robin read arbiter that shares the single SDRAM (MIG-style) read port between the command fetcher and the compute engines' data and weight streams. It sits between the requesters and the memory controller's command and read-data FIFO ports. It grants one burst at a time and issues the burst command. It then steers every returned beat back to the granted requester before re-arbitrating.

---
 rtl/dma_pkg.sv | 22 ++
 rtl/rr_pick.sv | 28 ++
 rtl/dma_rd_arbiter.sv | 128 ++++++++++++
 tb/tb_dma_rd_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// Shared constants, state encoding and helpers for the DMA read arbiter.
package dma_pkg;

  localparam int DMA_ADDR_W = 30;
  localparam int DMA_BL_W   = 6;
  localparam int DMA_DATA_W = 32;

  localparam int REQ_CMD    = 0;
  localparam int REQ_DATA   = 1;
  localparam int REQ_WEIGHT = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } arb_state_t;

  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin winner selection: rotate requests so the pointer sits at bit 0,
// take the lowest set bit, then rotate the index back.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [PTR_W-1:0]   winner,
  output logic               found
);

  logic [2*NUM_REQ-1:0] doubled;
  logic [NUM_REQ-1:0]   rotated;
  logic [PTR_W-1:0]     offset;

  always_comb begin
    doubled = {req, req};
    rotated = NUM_REQ'(doubled >> ptr);
    offset  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rotated[i]) offset = PTR_W'(i);
    end
    winner = PTR_W'((int'(ptr) + int'(offset)) % NUM_REQ);
    found  = |req;
  end

endmodule

// File: rtl/dma_rd_arbiter.sv
// Round-robin arbiter sharing one SDRAM read port: grants a burst, issues the
// command, then steers every returned beat to the owner. Option: DMA_ARB_PRIO0_EN.
module dma_rd_arbiter
  import dma_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = DMA_ADDR_W,
  parameter int BL_W    = DMA_BL_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*BL_W-1:0]   req_bl,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      cmd_en,
  output logic [ADDR_W-1:0]         cmd_addr,
  output logic [BL_W-1:0]           cmd_bl,
  input  logic                      cmd_full,
  output logic                      rd_en,
  input  logic                      rd_empty,
  input  logic [DMA_DATA_W-1:0]     rd_data,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DMA_DATA_W-1:0]     rsp_data,
  output logic                      rsp_last,
  output logic                      busy
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_t         state;
  logic [PTR_W-1:0]   gnt;
  logic [PTR_W-1:0]   rr_ptr;
  logic [BL_W-1:0]    beat_cnt;
  logic               gnt_prio;

  logic [PTR_W-1:0]   pick_idx;
  logic               pick_any;
  logic [PTR_W-1:0]   sel_idx;
  logic               sel_prio;

  logic               in_issue;
  logic               in_drain;
  logic               accept;
  logic               pop;
  logic [ADDR_W-1:0]  gnt_addr;
  logic [BL_W-1:0]    gnt_bl;
  logic [NUM_REQ-1:0] gnt_onehot;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_pick (
    .req    (req_valid),
    .ptr    (rr_ptr),
    .winner (pick_idx),
    .found  (pick_any)
  );

`ifdef DMA_ARB_PRIO0_EN
  // Command fetch jumps the queue; its grants leave rr_ptr alone so the others keep their turn.
  assign sel_prio = req_valid[REQ_CMD];
  assign sel_idx  = sel_prio ? PTR_W'(REQ_CMD) : pick_idx;
`else
  assign sel_prio = 1'b0;
  assign sel_idx  = pick_idx;
`endif

  always_comb begin
    gnt_addr   = req_addr[int'(gnt)*ADDR_W +: ADDR_W];
    gnt_bl     = req_bl[int'(gnt)*BL_W +: BL_W];
    gnt_onehot = NUM_REQ'(1) << gnt;
  end

  assign in_issue = (state == ISSUE);
  assign in_drain = (state == DRAIN);
  assign accept   = in_issue && !cmd_full;
  assign pop      = in_drain && !rd_empty;

  // Outputs are gated to zero outside their owning state so idle/reset values are clean.
  assign cmd_en    = accept;
  assign cmd_addr  = in_issue ? gnt_addr : '0;
  assign cmd_bl    = in_issue ? gnt_bl : '0;
  assign req_ready = accept ? gnt_onehot : '0;
  assign rd_en     = pop;
  assign rsp_valid = pop ? gnt_onehot : '0;
  assign rsp_data  = pop ? rd_data : '0;
  assign rsp_last  = pop && (beat_cnt == '0);
  assign busy      = in_issue || in_drain;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
      gnt_prio <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            gnt      <= sel_idx;
            gnt_prio <= sel_prio;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (accept) begin
            beat_cnt <= gnt_bl;
            state    <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop) begin
            if (beat_cnt == '0) begin
              state <= IDLE;
              if (!gnt_prio) rr_ptr <= PTR_W'(wrap_inc(int'(gnt), NUM_REQ));
            end else begin
              beat_cnt <= beat_cnt - BL_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_rd_arbiter.sv
// Self-checking bench for dma_rd_arbiter with requester and FWFT read-FIFO models.
// Define DMA_ARB_PRIO0_EN for both bench and RTL to check the priority variant.
module tb_dma_rd_arbiter;
  import dma_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 30;
  localparam int BL_W    = 6;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*BL_W-1:0]   req_bl;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      cmd_en;
  logic [ADDR_W-1:0]         cmd_addr;
  logic [BL_W-1:0]           cmd_bl;
  logic                      cmd_full = 1'b0;
  logic                      rd_en;
  logic                      rd_empty = 1'b1;
  logic [31:0]               rd_data = 32'h0;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [31:0]               rsp_data;
  logic                      rsp_last;
  logic                      busy;

  typedef struct {
    int                 idx;
    logic [ADDR_W-1:0]  addr;
    logic [BL_W-1:0]    bl;
  } pend_t;

  typedef struct {
    int                 idx;
    logic [ADDR_W-1:0]  addr;
    logic [BL_W-1:0]    bl;
    logic [NUM_REQ-1:0] exp_ready;
    int                 exp_beats;
  } vec_t;

  pend_t       pend[$];
  logic [63:0] exp_cmd_q[$];
  logic [63:0] exp_beat_q[$];
  logic [31:0] mem_q[$];

  int  checks = 0;
  int  errors = 0;
  int  beats_seen = 0;
  int  lasts_seen = 0;
  bit  gap_mode = 1'b0;
  bit  phase = 1'b0;

  dma_rd_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ADDR_W  (ADDR_W),
    .BL_W    (BL_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_bl    (req_bl),
    .req_ready (req_ready),
    .cmd_en    (cmd_en),
    .cmd_addr  (cmd_addr),
    .cmd_bl    (cmd_bl),
    .cmd_full  (cmd_full),
    .rd_en     (rd_en),
    .rd_empty  (rd_empty),
    .rd_data   (rd_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_last  (rsp_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic check_idle(input string name);
    check_output({name, "_cmd_side"}, 64'({req_ready, cmd_en, cmd_addr, cmd_bl, busy}), 64'd0);
    check_output({name, "_rsp_side"}, 64'({rd_en, rsp_valid, rsp_data, rsp_last}), 64'd0);
  endtask

  // Earliest queued burst per requester drives that requester's pins.
  task automatic update_req_pins();
    logic [NUM_REQ-1:0]        v = '0;
    logic [NUM_REQ*ADDR_W-1:0] a = '0;
    logic [NUM_REQ*BL_W-1:0]   b = '0;
    for (int p = pend.size() - 1; p >= 0; p--) begin
      v[pend[p].idx] = 1'b1;
      a[pend[p].idx*ADDR_W +: ADDR_W] = pend[p].addr;
      b[pend[p].idx*BL_W +: BL_W] = pend[p].bl;
    end
    req_valid = v;
    req_addr  = a;
    req_bl    = b;
  endtask

  task automatic apply_stimulus(input int idx, input logic [ADDR_W-1:0] addr, input logic [BL_W-1:0] bl);
    pend_t e;
    e.idx  = idx;
    e.addr = addr;
    e.bl   = bl;
    pend.push_back(e);
    update_req_pins();
  endtask

  task automatic expect_burst(input logic [NUM_REQ-1:0] ready, input logic [ADDR_W-1:0] addr, input logic [BL_W-1:0] bl);
    exp_cmd_q.push_back(64'({1'b1, ready, bl, addr}));
    for (int k = 0; k <= int'(bl); k++)
      exp_beat_q.push_back(64'({1'b1, ready, (k == int'(bl)), 32'(addr) + 32'(k)}));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (n < budget && !(exp_cmd_q.size() == 0 && exp_beat_q.size() == 0 && busy == 1'b0)) begin
      @(negedge clk);
      n++;
    end
    check_output({name, "_done"}, 64'(n < budget), 64'd1);
  endtask

  // Requesters drop a burst from their queue once its accept pulse is seen.
  initial begin
    logic [NUM_REQ-1:0] cap_ready;
    update_req_pins();
    forever begin
      @(negedge clk);
      cap_ready = req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (cap_ready[i]) begin
          for (int p = 0; p < pend.size(); p++) begin
            if (pend[p].idx == i) begin
              pend.delete(p);
              break;
            end
          end
        end
      end
      update_req_pins();
    end
  end

  // Memory model: each accepted command returns bl+1 beats of addr+k through a FWFT FIFO.
  initial begin
    logic              cap_rst, cap_pop, cap_cmd;
    logic [ADDR_W-1:0] cap_addr;
    logic [BL_W-1:0]   cap_bl;
    forever begin
      @(negedge clk);
      cap_rst  = rst;
      cap_pop  = rd_en;
      cap_cmd  = cmd_en;
      cap_addr = cmd_addr;
      cap_bl   = cmd_bl;
      @(posedge clk);
      #1;
      if (cap_rst) begin
        mem_q.delete();
      end else begin
        if (cap_pop && mem_q.size() > 0) void'(mem_q.pop_front());
        if (cap_cmd)
          for (int k = 0; k <= int'(cap_bl); k++) mem_q.push_back(32'(cap_addr) + 32'(k));
      end
      phase    = ~phase;
      rd_empty = (mem_q.size() == 0) || (gap_mode && phase);
      rd_data  = (mem_q.size() > 0) ? mem_q[0] : 32'h0;
    end
  end

  // Scoreboard: every issued command and every delivered beat is matched against the queues.
  initial begin
    forever begin
      @(negedge clk);
      if (cmd_en || req_ready != '0) begin
        if (exp_cmd_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_cmd: got ready=%b addr=%h, expected no command", req_ready, cmd_addr);
        end else begin
          check_output("cmd", 64'({cmd_en, req_ready, cmd_bl, cmd_addr}), exp_cmd_q.pop_front());
        end
      end
      if (rd_en || rsp_valid != '0 || rsp_last) begin
        beats_seen++;
        if (rsp_last) lasts_seen++;
        check_output("rd_en_in_drain", 64'(busy), 64'd1);
        if (exp_beat_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_beat: got valid=%b data=%h, expected no beat", rsp_valid, rsp_data);
        end else begin
          check_output("beat", 64'({rd_en, rsp_valid, rsp_last, rsp_data}), exp_beat_q.pop_front());
        end
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got timeout, expected bench completion");
    $fatal(1);
  end

  initial begin
    vec_t vecs[4];
    int   b0, l0, n;

    vecs[0] = '{REQ_DATA,   30'h0001_2340, 6'd3,  4'b0010, 4};
    vecs[1] = '{REQ_WEIGHT, 30'h3FFF_FFC0, 6'd63, 4'b0100, 64};
    vecs[2] = '{3,          30'h0000_0100, 6'd0,  4'b1000, 1};
    vecs[3] = '{REQ_CMD,    30'h2000_0000, 6'd7,  4'b0001, 8};

    $display("[TB] reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    tick();
    rst = 1'b0;

    $display("[TB] all four requesters, bl=3");
    apply_stimulus(0, 30'h0000_1000, 6'd3);
    apply_stimulus(1, 30'h0000_2000, 6'd3);
    apply_stimulus(2, 30'h0000_3000, 6'd3);
    apply_stimulus(3, 30'h0000_4000, 6'd3);
    apply_stimulus(0, 30'h0000_5000, 6'd3);
`ifdef DMA_ARB_PRIO0_EN
    expect_burst(4'b0001, 30'h0000_1000, 6'd3);
    expect_burst(4'b0001, 30'h0000_5000, 6'd3);
    expect_burst(4'b0010, 30'h0000_2000, 6'd3);
    expect_burst(4'b0100, 30'h0000_3000, 6'd3);
    expect_burst(4'b1000, 30'h0000_4000, 6'd3);
`else
    expect_burst(4'b0001, 30'h0000_1000, 6'd3);
    expect_burst(4'b0010, 30'h0000_2000, 6'd3);
    expect_burst(4'b0100, 30'h0000_3000, 6'd3);
    expect_burst(4'b1000, 30'h0000_4000, 6'd3);
    expect_burst(4'b0001, 30'h0000_5000, 6'd3);
`endif
    wait_done("rr_all4", 300);

    $display("[TB] single-beat burst latency");
    tick();
    apply_stimulus(1, 30'h00A_0000, 6'd0);
    expect_burst(4'b0010, 30'h00A_0000, 6'd0);
    @(negedge clk);
    check_output("single_idle_cycle", 64'(cmd_en), 64'd0);
    @(negedge clk);
    check_output("single_cmd", 64'({cmd_en, cmd_addr}), 64'({1'b1, 30'h00A_0000}));
    @(negedge clk);
    check_output("single_beat", 64'({rsp_valid, rsp_last}), 64'({4'b0010, 1'b1}));
    @(negedge clk);
    check_output("single_busy_fall", 64'(busy), 64'd0);
    wait_done("single", 20);

    $display("[TB] table of single-requester bursts");
    for (int v = 0; v < 4; v++) begin
      tick();
      b0 = beats_seen;
      apply_stimulus(vecs[v].idx, vecs[v].addr, vecs[v].bl);
      expect_burst(vecs[v].exp_ready, vecs[v].addr, vecs[v].bl);
      wait_done("table", 200);
      check_output("table_beats", 64'(beats_seen - b0), 64'(vecs[v].exp_beats));
    end

    $display("[TB] cmd_full stall");
    tick();
    cmd_full = 1'b1;
    apply_stimulus(2, 30'h0000_7700, 6'd1);
    expect_burst(4'b0100, 30'h0000_7700, 6'd1);
    @(negedge clk);
    check_output("stall_idle", 64'(busy), 64'd0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check_output("stall_hold", 64'({cmd_en, req_ready, busy}), 64'({1'b0, 4'b0000, 1'b1}));
    end
    tick();
    cmd_full = 1'b0;
    @(negedge clk);
    check_output("stall_pulse", 64'({cmd_en, req_ready}), 64'({1'b1, 4'b0100}));
    @(negedge clk);
    check_output("stall_pulse_end", 64'({cmd_en, req_ready}), 64'd0);
    wait_done("stall", 30);

    $display("[TB] rd_empty toggling, 8-beat burst");
    tick();
    gap_mode = 1'b1;
    b0 = beats_seen;
    l0 = lasts_seen;
    apply_stimulus(3, 30'h0005_0000, 6'd7);
    expect_burst(4'b1000, 30'h0005_0000, 6'd7);
    wait_done("gap", 60);
    check_output("gap_pops", 64'(beats_seen - b0), 64'd8);
    check_output("gap_lasts", 64'(lasts_seen - l0), 64'd1);
    gap_mode = 1'b0;

    $display("[TB] reset mid-drain");
    tick();
    apply_stimulus(1, 30'h0000_0A00, 6'd0);
    expect_burst(4'b0010, 30'h0000_0A00, 6'd0);
    wait_done("pre_reset", 20);
    tick();
    b0 = beats_seen;
    apply_stimulus(3, 30'h0000_0B00, 6'd3);
    expect_burst(4'b1000, 30'h0000_0B00, 6'd3);
    n = 0;
    while (beats_seen < b0 + 2 && n < 100) begin
      @(posedge clk);
      n++;
    end
    check_output("reset_wait", 64'(n < 100), 64'd1);
    #1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_idle("mid_reset");
    exp_beat_q.delete();
    tick();
    apply_stimulus(1, 30'h0000_0C00, 6'd1);
    apply_stimulus(2, 30'h0000_0D00, 6'd1);
    expect_burst(4'b0010, 30'h0000_0C00, 6'd1);
    expect_burst(4'b0100, 30'h0000_0D00, 6'd1);
    wait_done("post_reset", 60);

    $display("[TB] req 0 and req 2 with rr_ptr at 2");
    tick();
    apply_stimulus(1, 30'h0000_0E00, 6'd0);
    expect_burst(4'b0010, 30'h0000_0E00, 6'd0);
    wait_done("ptr_setup", 20);
    tick();
    apply_stimulus(0, 30'h0000_0F00, 6'd1);
    apply_stimulus(2, 30'h0000_1F00, 6'd1);
`ifdef DMA_ARB_PRIO0_EN
    expect_burst(4'b0001, 30'h0000_0F00, 6'd1);
    expect_burst(4'b0100, 30'h0000_1F00, 6'd1);
`else
    expect_burst(4'b0100, 30'h0000_1F00, 6'd1);
    expect_burst(4'b0001, 30'h0000_0F00, 6'd1);
`endif
    wait_done("prio", 60);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
